// File: rtl/wb_regfile.sv
// Register file with write-back port, two combinational read ports and a busy-bit scoreboard.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
module wb_regfile #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ASIZE-1:0]      waddr,
  input  logic [DSIZE-1:0]      wdata,
  input  logic [ASIZE-1:0]      raddr1,
  input  logic [ASIZE-1:0]      raddr2,
  output logic [DSIZE-1:0]      rdata1,
  output logic [DSIZE-1:0]      rdata2,
  input  logic                  issue_en,
  input  logic [ASIZE-1:0]      issue_addr,
  output logic                  stall,
  output logic [(2**ASIZE)-1:0] busy_vec
);

  localparam int NREG = 2 ** ASIZE;

  logic [DSIZE-1:0] regs_r [NREG];
  logic [NREG-1:0]  busy_r;
  logic [NREG-1:0]  busy_nxt_s;
  logic             hit1_s;
  logic             hit2_s;
  logic             pend1_s;
  logic             pend2_s;
  logic             stall_s;
  logic             issue_accept_s;

  // Read ports, forwarding hits and stall; all outputs held at zero while in reset.
  always_comb begin
`ifdef WB_BYPASS_EN
    hit1_s = wen && (waddr == raddr1) && (raddr1 != {ASIZE{1'b0}});
    hit2_s = wen && (waddr == raddr2) && (raddr2 != {ASIZE{1'b0}});
`else
    hit1_s = 1'b0;
    hit2_s = 1'b0;
`endif
    pend1_s = busy_r[raddr1] && !hit1_s;
    pend2_s = busy_r[raddr2] && !hit2_s;
    if (!rst) begin
      stall_s = 1'b0;
      rdata1  = {DSIZE{1'b0}};
      rdata2  = {DSIZE{1'b0}};
    end else begin
      stall_s = pend1_s || pend2_s;
      rdata1  = hit1_s ? wdata : regs_r[raddr1];
      rdata2  = hit2_s ? wdata : regs_r[raddr2];
    end
  end

  assign stall          = stall_s;
  assign busy_vec       = busy_r;
  assign issue_accept_s = rst && issue_en && !stall_s;

  // Scoreboard next state: write-back clears first so a same-cycle issue to that register wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wen) begin
      busy_nxt_s[waddr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (issue_accept_s) begin
      busy_nxt_s[issue_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Register storage; r0 is never written and stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DSIZE{1'b0}};
      end
    end else if (wen && (waddr != {ASIZE{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared every cycle against an array-based register/scoreboard model.
module tb_wb_regfile;
  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int NREG  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wen = 1'b0;
  logic [ASIZE-1:0] waddr = '0;
  logic [DSIZE-1:0] wdata = '0;
  logic [ASIZE-1:0] raddr1 = '0;
  logic [ASIZE-1:0] raddr2 = '0;
  logic [DSIZE-1:0] rdata1;
  logic [DSIZE-1:0] rdata2;
  logic             issue_en = 1'b0;
  logic [ASIZE-1:0] issue_addr = '0;
  logic             stall;
  logic [NREG-1:0]  busy_vec;

  int vectors = 0;
  int miscompares = 0;

  logic [DSIZE-1:0] m_regs [NREG];
  logic [NREG-1:0]  m_busy;

  always #5 clk = ~clk;

  wb_regfile #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .issue_en(issue_en), .issue_addr(issue_addr), .stall(stall), .busy_vec(busy_vec)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic forwarded(input logic [ASIZE-1:0] a);
`ifdef WB_BYPASS_EN
    return wen && (waddr == a) && (a != 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DSIZE-1:0] exp_rd(input logic [ASIZE-1:0] a);
    if (!rst) return 16'h0000;
    if (forwarded(a)) return wdata;
    if (a == 4'd0) return 16'h0000;
    return m_regs[a];
  endfunction

  function automatic logic exp_stall();
    if (!rst) return 1'b0;
    return (m_busy[raddr1] && !forwarded(raddr1)) || (m_busy[raddr2] && !forwarded(raddr2));
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] <= 16'h0000;
      m_busy <= 16'h0000;
    end else begin
      automatic logic [NREG-1:0] nb = m_busy;
      automatic logic            s  = exp_stall();
      if (wen && waddr != 4'd0) m_regs[waddr] <= wdata;
      if (wen) nb[waddr] = 1'b0;
      if (issue_en && !s && issue_addr != 4'd0) nb[issue_addr] = 1'b1;
      m_busy <= nb;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check("rdata1", 32'(rdata1), 32'(exp_rd(raddr1)));
    check("rdata2", 32'(rdata2), 32'(exp_rd(raddr2)));
    check("stall", 32'(stall), 32'(exp_stall()));
    check("busy_vec", 32'(busy_vec), 32'(m_busy));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0;
    issue_en = 1'b0;
  endtask

  function automatic logic [ASIZE-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_busy", 32'(busy_vec), 32'h0);

    // Asynchronous reset clears stored data immediately.
    wen = 1'b1; waddr = 4'd3; wdata = 16'h1234;
    cyc(); idle(); raddr1 = 4'd3;
    #1 check("r3_before_reset", 32'(rdata1), 32'h1234);
    #1 rst = 1'b0;
    #1 check("r3_in_reset", 32'(rdata1), 32'h0);
    check("busy_in_reset", 32'(busy_vec), 32'h0);
    check("stall_in_reset", 32'(stall), 32'h0);
    cyc(); rst = 1'b1;
    #1 check("r3_after_reset", 32'(rdata1), 32'h0);

    // Basic write and r0 protection.
    wen = 1'b1; waddr = 4'd5; wdata = 16'hBEEF;
    cyc(); wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; raddr1 = 4'd5; raddr2 = 4'd0;
    #1 check("r5_read", 32'(rdata1), 32'hBEEF);
    cyc(); idle();
    #1 check("r0_read", 32'(rdata2), 32'h0);

    // Scoreboard stall, ignored issue while stalled, release on write-back.
    raddr1 = 4'd0; raddr2 = 4'd0; issue_en = 1'b1; issue_addr = 4'd7;
    cyc(); issue_addr = 4'd9; raddr2 = 4'd7;
    #1 check("r7_stall", 32'(stall), 32'h1);
    cyc(); issue_en = 1'b0;
    #1 check("issue_ignored", 32'(busy_vec), 32'h0080);
    wen = 1'b1; waddr = 4'd7; wdata = 16'h0042;
`ifdef WB_BYPASS_EN
    #1 check("r7_bypass_stall", 32'(stall), 32'h0);
    check("r7_bypass_data", 32'(rdata2), 32'h0042);
`else
    #1 check("r7_wb_stall", 32'(stall), 32'h1);
`endif
    cyc(); idle();
    #1 check("r7_released", 32'(stall), 32'h0);
    check("r7_data", 32'(rdata2), 32'h0042);
    check("r7_busy_clear", 32'(busy_vec), 32'h0);

    // Same-cycle issue and write-back to r4: data written, busy stays set.
    raddr2 = 4'd0; issue_en = 1'b1; issue_addr = 4'd4; wen = 1'b1; waddr = 4'd4; wdata = 16'h0011;
    cyc(); idle(); raddr1 = 4'd4;
    #1 check("r4_busy", 32'(busy_vec), 32'h0010);
    check("r4_stall", 32'(stall), 32'h1);
    check("r4_data", 32'(rdata1), 32'h0011);
    wen = 1'b1; waddr = 4'd4; wdata = 16'h0011; raddr1 = 4'd0;
    cyc(); idle();

    // Two busy sources; stall persists until both are written back.
    issue_en = 1'b1; issue_addr = 4'd2;
    cyc(); issue_addr = 4'd9;
    cyc(); idle(); raddr1 = 4'd2; raddr2 = 4'd9;
    #1 check("dual_stall", 32'(stall), 32'h1);
    wen = 1'b1; waddr = 4'd2; wdata = 16'h2222;
    cyc(); idle();
    #1 check("dual_one_left", 32'(stall), 32'h1);
    check("dual_busy", 32'(busy_vec), 32'h0200);
    wen = 1'b1; waddr = 4'd9; wdata = 16'h9999;
    cyc(); idle();
    #1 check("dual_clear", 32'(stall), 32'h0);
    check("dual_r9", 32'(rdata2), 32'h9999);

    // Randomized traffic with occasional mid-cycle reset.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!rst) rst = 1'b1;
      wen        = ($urandom_range(0, 2) == 0);
      waddr      = rnd_addr();
      wdata      = 16'($urandom);
      raddr1     = rnd_addr();
      raddr2     = rnd_addr();
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = rnd_addr();
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b0;
      end
    end
    cyc(); idle(); rst = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
